// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares a single synchronous FIFO write port between
// NUM_REQ valid/ready burst producers. One producer owns the write port at a
// time. Ownership lasts until that producer marks the last beat, or until
// MAX_BURST beats have been written. A truncated producer then competes again.
// Every grant is preceded by one IDLE arbitration cycle. Writes are suppressed
// whenever the FIFO reports full.
//
// Ports
//   i_clk           clock, all logic on the rising edge
//   i_rst           synchronous active-high reset
//   i_req_valid     per-requester beat valid
//   i_req_last      per-requester end-of-burst marker, qualified by valid
//   i_req_data      requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready     per-requester ready; only the grantee can see it high
//   i_fifo_full     FIFO full flag, same cycle
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_wr_data  FIFO write data (0 outside a grant)
//   o_grant_id      index of the current or most recent grantee
//   o_busy          high while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  output logic [IDX_WIDTH-1:0]          o_grant_id,
  output logic                          o_busy
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [IDX_WIDTH-1:0] TOP_IDX   = IDX_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  // Unpacked view of the per-requester data so the grantee can be selected by index.
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search. The search starts one past the last requester served,
  // so the requester just served has the lowest priority.
  logic                 pick_found;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic [IDX_WIDTH-1:0] cand_idx;

  // NOTE: every signal assigned in an always_comb gets a default at the top.
  // Otherwise any path that misses an assignment infers a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = IDX_WIDTH'((int'(last_idx_q) + off) % NUM_REQ);
      if (!pick_found && i_req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Write-side outputs are combinational from the current inputs. The FIFO
  // therefore samples the beat on the same edge the arbiter counts it.
  always_comb begin
    o_req_ready    = '0;
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = '0;
    if (state_q == S_GRANT) begin
      o_req_ready[grant_idx_q] = !i_fifo_full;
      o_fifo_wr_en             = i_req_valid[grant_idx_q] & !i_fifo_full;
      o_fifo_wr_data           = req_data[grant_idx_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        // The grant and the beat count both hold while the FIFO is full or
        // while the grantee has no valid beat.
        if (o_fifo_wr_en) begin
          if (i_req_last[grant_idx_q] || beat_cnt_q == LAST_BEAT) begin
            last_idx_d = grant_idx_q;
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // updates from values sampled before the edge, whatever order the statements run in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= TOP_IDX;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign o_grant_id = grant_idx_q;
  assign o_busy     = (state_q == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed scenarios for reset, a single burst, round-robin order, MAX_BURST
// truncation, FIFO back-pressure, a grantee dropping valid, and reset during a
// burst. A randomized run follows. In that run, per-producer beat queues and a
// rule-level arbitration model predict every cycle's outputs.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled
// 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    i_req_last;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_ready;
  logic            i_fifo_full;
  logic            o_fifo_wr_en;
  logic [DW-1:0]   o_fifo_wr_data;
  logic [IW-1:0]   o_grant_id;
  logic            o_busy;

  // Per-requester stimulus, packed onto the DUT buses below.
  logic          req_v [N];
  logic          req_l [N];
  logic [DW-1:0] req_d [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign i_req_valid[g]          = req_v[g];
    assign i_req_last[g]           = req_l[g];
    assign i_req_data[g*DW +: DW]  = req_d[g];
  end

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .IDX_WIDTH  (IW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .i_req_last     (i_req_last),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .i_fifo_full    (i_fifo_full),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .o_fifo_wr_data (o_fifo_wr_data),
    .o_grant_id     (o_grant_id),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          busy;
    logic [IW-1:0] gid;
    logic          en;
    logic [N-1:0]  rdy;
    logic [DW-1:0] data;
  } obs_t;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  function automatic obs_t observe();
    obs_t o;
    o.busy = o_busy;
    o.gid  = o_grant_id;
    o.en   = o_fifo_wr_en;
    o.rdy  = o_req_ready;
    o.data = o_fifo_wr_data;
    return o;
  endfunction

  // rdy_bit < 0 means no ready bit is set.
  function automatic obs_t exp_obs(logic busy, int gid, logic en, int rdy_bit, logic [DW-1:0] data);
    obs_t e;
    e.busy = busy;
    e.gid  = IW'(gid);
    e.en   = en;
    e.rdy  = (rdy_bit < 0) ? '0 : (N'(1) << rdy_bit);
    e.data = data;
    return e;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(int k, logic v, logic l, logic [DW-1:0] d);
    req_v[k] = v;
    req_l[k] = l;
    req_d[k] = d;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, '0);
    i_fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    i_rst = 1'b1;
    clear_inputs();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, 32'hFFFF_0000 + k);
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      e = exp_obs(1'b0, 0, 1'b0, -1, '0);
      total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL reset c%0d: got %p expected %p", c, observe(), e);
      end
    end
    i_rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_burst();
    obs_t e;
    set_req(2, 1'b1, 1'b0, 32'hA0);
    settle();
    e = exp_obs(1'b0, 0, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL single_idle: got %p expected %p", observe(), e); end
    for (int b = 0; b < 3; b++) begin
      tick();
      set_req(2, 1'b1, (b == 2), 32'hA0 + b);
      settle();
      e = exp_obs(1'b1, 2, 1'b1, 2, 32'hA0 + b);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL single_beat%0d: got %p expected %p", b, observe(), e); end
    end
    tick();
    set_req(2, 1'b0, 1'b0, '0);
    settle();
    e = exp_obs(1'b0, 2, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL single_end: got %p expected %p", observe(), e); end
  endtask

  task automatic test_round_robin();
    obs_t e;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, 32'hB000_0000 + k);
    for (int g = 0; g < 5; g++) begin
      settle();
      e = exp_obs(1'b0, (g == 0) ? 0 : (g - 1) % N, 1'b0, -1, '0);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL rr_idle%0d: got %p expected %p", g, observe(), e); end
      tick();
      settle();
      e = exp_obs(1'b1, g % N, 1'b1, g % N, 32'hB000_0000 + (g % N));
      total++;
      if (observe() !== e) begin bad++; $display("FAIL rr_grant%0d: got %p expected %p", g, observe(), e); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_max_burst();
    obs_t e;
    do_reset();
    set_req(1, 1'b1, 1'b0, 32'hC0);
    settle();
    e = exp_obs(1'b0, 0, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL maxb_idle: got %p expected %p", observe(), e); end
    for (int i = 0; i < 6; i++) begin
      tick();
      set_req(1, 1'b1, (i == 5), 32'hC0 + i);
      settle();
      if (i == 4) begin
        // Truncation after MAX_BURST beats forces a re-arbitration bubble.
        e = exp_obs(1'b0, 1, 1'b0, -1, '0);
        total++;
        if (observe() !== e) begin bad++; $display("FAIL maxb_bubble: got %p expected %p", observe(), e); end
        tick();
        settle();
      end
      e = exp_obs(1'b1, 1, 1'b1, 1, 32'hC0 + i);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL maxb_beat%0d: got %p expected %p", i, observe(), e); end
    end
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    settle();
    e = exp_obs(1'b0, 1, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL maxb_end: got %p expected %p", observe(), e); end
  endtask

  task automatic test_fifo_full();
    obs_t e;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hD0);
    settle();
    tick();
    settle();
    e = exp_obs(1'b1, 0, 1'b1, 0, 32'hD0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL full_beat0: got %p expected %p", observe(), e); end
    tick();
    i_fifo_full = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'hD1);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) tick();
      settle();
      e = exp_obs(1'b1, 0, 1'b0, -1, 32'hD1);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL full_hold%0d: got %p expected %p", c, observe(), e); end
    end
    tick();
    i_fifo_full = 1'b0;
    // No last marker: the burst ends only when the 4th beat reaches MAX_BURST.
    // A beat count that advanced while full would end the burst early.
    for (int b = 1; b < 4; b++) begin
      if (b != 1) tick();
      set_req(0, 1'b1, 1'b0, 32'hD0 + b);
      settle();
      e = exp_obs(1'b1, 0, 1'b1, 0, 32'hD0 + b);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL full_beat%0d: got %p expected %p", b, observe(), e); end
    end
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    settle();
    e = exp_obs(1'b0, 0, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL full_end: got %p expected %p", observe(), e); end
  endtask

  task automatic test_drop_valid();
    obs_t e;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hE0);
    set_req(3, 1'b1, 1'b1, 32'hF3);
    settle();
    tick();
    settle();
    e = exp_obs(1'b1, 0, 1'b1, 0, 32'hE0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL drop_beat0: got %p expected %p", observe(), e); end
    tick();
    set_req(0, 1'b0, 1'b0, 32'hE1);
    for (int c = 0; c < 2; c++) begin
      if (c != 0) tick();
      settle();
      e = exp_obs(1'b1, 0, 1'b0, 0, 32'hE1);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL drop_hold%0d: got %p expected %p", c, observe(), e); end
    end
    for (int b = 1; b < 3; b++) begin
      tick();
      set_req(0, 1'b1, (b == 2), 32'hE0 + b);
      settle();
      e = exp_obs(1'b1, 0, 1'b1, 0, 32'hE0 + b);
      total++;
      if (observe() !== e) begin bad++; $display("FAIL drop_beat%0d: got %p expected %p", b, observe(), e); end
    end
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    settle();
    e = exp_obs(1'b0, 0, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL drop_bubble: got %p expected %p", observe(), e); end
    tick();
    settle();
    e = exp_obs(1'b1, 3, 1'b1, 3, 32'hF3);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL drop_req3: got %p expected %p", observe(), e); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    obs_t e;
    do_reset();
    set_req(2, 1'b1, 1'b0, 32'h60);
    settle();
    tick();
    settle();
    tick();
    set_req(2, 1'b1, 1'b0, 32'h61);
    i_rst = 1'b1;
    settle();
    e = exp_obs(1'b1, 2, 1'b1, 2, 32'h61);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL rstmid_beat1: got %p expected %p", observe(), e); end
    tick();
    settle();
    e = exp_obs(1'b0, 0, 1'b0, -1, '0);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL rstmid_after: got %p expected %p", observe(), e); end
    i_rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h70);
    tick();
    settle();
    e = exp_obs(1'b1, 0, 1'b1, 0, 32'h70);
    total++;
    if (observe() !== e) begin bad++; $display("FAIL rstmid_req0: got %p expected %p", observe(), e); end
    tick();
    clear_inputs();
  endtask

  // Randomized traffic against a rule-level model. Producers own queues of
  // bursts, and a beat leaves its queue only when the model accepts it. The
  // model grants the first valid requester after the last one served, ends a
  // grant on last or after MB beats, and never writes while full.
  task automatic test_random();
    beat_t pq [N][$];
    obs_t  e;
    logic  m_busy  = 1'b0;
    int    m_g     = 0;
    int    m_last  = N - 1;
    int    m_beats = 0;
    int    errs    = 0;
    int    len;
    logic  vk, en;
    beat_t b;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_fifo_full = ($urandom_range(3) == 0);
      for (int k = 0; k < N; k++) begin
        if (pq[k].size() == 0 && $urandom_range(2) == 0) begin
          len = $urandom_range(6, 1);
          for (int j = 0; j < len; j++) begin
            b.l = (j == len - 1);
            b.d = $urandom;
            pq[k].push_back(b);
          end
        end
        vk = (pq[k].size() != 0);
        // Only the grantee may withdraw valid; everyone else holds it.
        if (vk && m_busy && m_g == k && $urandom_range(4) == 0) vk = 1'b0;
        if (pq[k].size() != 0) set_req(k, vk, vk & pq[k][0].l, pq[k][0].d);
        else set_req(k, 1'b0, 1'b0, $urandom);
      end
      settle();
      if (m_busy) begin
        en = req_v[m_g] & !i_fifo_full;
        e  = exp_obs(1'b1, m_g, en, i_fifo_full ? -1 : m_g, req_d[m_g]);
      end else begin
        en = 1'b0;
        e  = exp_obs(1'b0, m_g, 1'b0, -1, '0);
      end
      total++;
      if (observe() !== e) begin
        bad++;
        if (errs < 10) $display("FAIL random cyc%0d: got %p expected %p", cyc, observe(), e);
        errs++;
      end
      if (m_busy) begin
        if (en) begin
          b = pq[m_g].pop_front();
          m_beats++;
          if (b.l || m_beats == MB) begin
            m_busy = 1'b0;
            m_last = m_g;
          end
        end
      end else begin
        for (int off = 1; off <= N; off++) begin
          if (!m_busy && req_v[(m_last + off) % N]) begin
            m_busy  = 1'b1;
            m_g     = (m_last + off) % N;
            m_beats = 0;
          end
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    i_rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_fifo_full();
    test_drop_valid();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
